// File: rtl/dmem_port_arbiter.sv
// Two-requester front end for the single-ported data memory: arbitrates, checks range and
// alignment, drives one access onto the dmemory pins, and returns a tagged response.
module dmem_port_arbiter #(
   parameter logic [31:0] MEM_BASE     = 32'h0100_0000,
   parameter int unsigned MEM_BYTES    = 4096,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        p0_req_valid,
   output logic        p0_req_ready,
   input  logic [31:0] p0_req_addr,
   input  logic [31:0] p0_req_wdata,
   input  logic        p0_req_we,
   input  logic        p0_req_sign,
   input  logic [1:0]  p0_req_size,
   input  logic        p1_req_valid,
   output logic        p1_req_ready,
   input  logic [31:0] p1_req_addr,
   input  logic [31:0] p1_req_wdata,
   input  logic        p1_req_we,
   input  logic        p1_req_sign,
   input  logic [1:0]  p1_req_size,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_port,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] mem_address,
   output logic [31:0] mem_data_in,
   output logic        mem_read_write,
   output logic        mem_is_sign,
   output logic [1:0]  mem_access_size,
   input  logic [31:0] mem_data_out
);

   localparam int unsigned CNT_W    = $clog2(STARVE_LIMIT + 2);
   localparam logic [32:0] MEM_LAST = {1'b0, MEM_BASE} + 33'(MEM_BYTES) - 33'd1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   starve_cnt_q, starve_cnt_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic               rsp_port_q, rsp_port_d;
   logic [31:0]        rsp_rdata_q, rsp_rdata_d;
   logic               rsp_err_q, rsp_err_d;
   logic [31:0]        mem_address_q, mem_address_d;
   logic [31:0]        mem_data_in_q, mem_data_in_d;
   logic               mem_read_write_q, mem_read_write_d;
   logic               mem_is_sign_q, mem_is_sign_d;
   logic [1:0]         mem_access_size_q, mem_access_size_d;

   logic               idle_c;
   logic               force_p1_c;
   logic               grant0_c;
   logic               grant1_c;
   logic [31:0]        sel_addr;
   logic [31:0]        sel_wdata;
   logic               sel_we;
   logic               sel_sign;
   logic [1:0]         sel_size;
   logic [1:0]         sel_span;
   logic [32:0]        sel_last;
   logic               sel_err;

   // Grant only in IDLE; port 1 is forced once it has been passed over STARVE_LIMIT times.
   assign idle_c     = (state_q == IDLE) && !reset;
   assign force_p1_c = p1_req_valid && (starve_cnt_q == CNT_W'(STARVE_LIMIT));
   assign grant0_c   = idle_c && p0_req_valid && !force_p1_c;
   assign grant1_c   = idle_c && p1_req_valid && !grant0_c;

   assign p0_req_ready = grant0_c;
   assign p1_req_ready = grant1_c;

   // Selected request and its legality; the end address is formed in 33 bits so it cannot wrap.
   always_comb begin
      sel_addr  = grant1_c ? p1_req_addr  : p0_req_addr;
      sel_wdata = grant1_c ? p1_req_wdata : p0_req_wdata;
      sel_we    = grant1_c ? p1_req_we    : p0_req_we;
      sel_sign  = grant1_c ? p1_req_sign  : p0_req_sign;
      sel_size  = grant1_c ? p1_req_size  : p0_req_size;
      case (sel_size)
         2'b00:   sel_span = 2'd0;
         2'b01:   sel_span = 2'd1;
         default: sel_span = 2'd3;
      endcase
      sel_last = {1'b0, sel_addr} + {31'd0, sel_span};
      sel_err  = (sel_size == 2'b11)
              || ((sel_size == 2'b01) && sel_addr[0])
              || ((sel_size == 2'b10) && (sel_addr[1:0] != 2'b00))
              || (sel_addr < MEM_BASE)
              || (sel_last > MEM_LAST);
   end

   always_comb begin
      state_d           = state_q;
      starve_cnt_d      = starve_cnt_q;
      rsp_valid_d       = rsp_valid_q;
      rsp_port_d        = rsp_port_q;
      rsp_rdata_d       = rsp_rdata_q;
      rsp_err_d         = rsp_err_q;
      mem_address_d     = mem_address_q;
      mem_data_in_d     = mem_data_in_q;
      mem_read_write_d  = 1'b0;
      mem_is_sign_d     = mem_is_sign_q;
      mem_access_size_d = mem_access_size_q;

      case (state_q)
         IDLE: begin
            if (grant0_c || grant1_c) begin
               if (grant1_c) begin
                  starve_cnt_d = '0;
               end else if (p1_req_valid && (starve_cnt_q != CNT_W'(STARVE_LIMIT))) begin
                  starve_cnt_d = starve_cnt_q + CNT_W'(1);
               end
               rsp_port_d = grant1_c;
               if (sel_err) begin
                  // Rejected requests never touch the memory pins.
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = '0;
                  rsp_valid_d = 1'b1;
                  state_d     = RESP;
               end else begin
                  mem_address_d     = sel_addr;
                  mem_data_in_d     = sel_wdata;
                  mem_read_write_d  = sel_we;
                  mem_is_sign_d     = sel_sign;
                  mem_access_size_d = sel_size;
                  state_d           = ACCESS;
               end
            end
         end
         ACCESS: begin
            rsp_err_d   = 1'b0;
            rsp_rdata_d = mem_read_write_q ? 32'h0 : mem_data_out;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q           <= IDLE;
         starve_cnt_q      <= '0;
         rsp_valid_q       <= 1'b0;
         rsp_port_q        <= 1'b0;
         rsp_rdata_q       <= '0;
         rsp_err_q         <= 1'b0;
         mem_address_q     <= '0;
         mem_data_in_q     <= '0;
         mem_read_write_q  <= 1'b0;
         mem_is_sign_q     <= 1'b0;
         mem_access_size_q <= '0;
      end else begin
         state_q           <= state_d;
         starve_cnt_q      <= starve_cnt_d;
         rsp_valid_q       <= rsp_valid_d;
         rsp_port_q        <= rsp_port_d;
         rsp_rdata_q       <= rsp_rdata_d;
         rsp_err_q         <= rsp_err_d;
         mem_address_q     <= mem_address_d;
         mem_data_in_q     <= mem_data_in_d;
         mem_read_write_q  <= mem_read_write_d;
         mem_is_sign_q     <= mem_is_sign_d;
         mem_access_size_q <= mem_access_size_d;
      end
   end

   assign rsp_valid       = rsp_valid_q;
   assign rsp_port        = rsp_port_q;
   assign rsp_rdata       = rsp_rdata_q;
   assign rsp_err         = rsp_err_q;
   assign mem_address     = mem_address_q;
   assign mem_data_in     = mem_data_in_q;
   assign mem_read_write  = mem_read_write_q;
   assign mem_is_sign     = mem_is_sign_q;
   assign mem_access_size = mem_access_size_q;

endmodule
